// File: rtl/fir8_lowpass_core_if.sv
// Sample-load, output-select and read-back bundle for fir8_lowpass_core.
// out_valid exists only when FIR8_OUT_VALID_EN is defined.
interface fir8_lowpass_core_if #(
    parameter int DW = 8,
    parameter int OW = 18
);
    logic          write;
    logic [DW-1:0] c0;
    logic [DW-1:0] c1;
    logic [DW-1:0] c2;
    logic [DW-1:0] c3;
    logic [DW-1:0] c4;
    logic [DW-1:0] c5;
    logic [DW-1:0] c6;
    logic [DW-1:0] c7;
    logic [2:0]    addr;
    logic [OW-1:0] out_data;
    logic [2:0]    mem_addr;
    logic [DW-1:0] mem_data;
`ifdef FIR8_OUT_VALID_EN
    logic          out_valid;

    modport master (
        output write,
        output c0, c1, c2, c3,
        output c4, c5, c6, c7,
        output addr,
        output mem_addr,
        input  out_data,
        input  mem_data,
        input  out_valid
    );

    modport slave (
        input  write,
        input  c0, c1, c2, c3,
        input  c4, c5, c6, c7,
        input  addr,
        input  mem_addr,
        output out_data,
        output mem_data,
        output out_valid
    );
`else
    modport master (
        output write,
        output c0, c1, c2, c3,
        output c4, c5, c6, c7,
        output addr,
        output mem_addr,
        input  out_data,
        input  mem_data
    );

    modport slave (
        input  write,
        input  c0, c1, c2, c3,
        input  c4, c5, c6, c7,
        input  addr,
        input  mem_addr,
        output out_data,
        output mem_data
    );
`endif
endinterface

// File: rtl/fir8_lowpass_core.sv
// 8-tap fixed-coefficient FIR with parallel-load sample file.
// Optional macro FIR8_OUT_VALID_EN adds the out_valid flag.
module fir8_lowpass_core #(
    parameter int DW = 8,
    parameter int OW = 18,
    parameter logic [7:0] H0 = 8'd4,
    parameter logic [7:0] H1 = 8'd12,
    parameter logic [7:0] H2 = 8'd30,
    parameter logic [7:0] H3 = 8'd46,
    parameter logic [7:0] H4 = 8'd46,
    parameter logic [7:0] H5 = 8'd30,
    parameter logic [7:0] H6 = 8'd12,
    parameter logic [7:0] H7 = 8'd4
) (
    input  logic               clk,
    input  logic               rstFIR,
    fir8_lowpass_core_if.slave bus
);
    localparam int PW = DW + 8;

    localparam logic [7:0] H [8] = '{
        H0, H1, H2, H3, H4, H5, H6, H7
    };

    logic [DW-1:0] x [8];
    logic [OW-1:0] y [8];

    // Sample file: a load wins over reset so both can coincide.
    always_ff @(posedge clk) begin
        if (bus.write) begin
            x[0] <= bus.c0;
            x[1] <= bus.c1;
            x[2] <= bus.c2;
            x[3] <= bus.c3;
            x[4] <= bus.c4;
            x[5] <= bus.c5;
            x[6] <= bus.c6;
            x[7] <= bus.c7;
        end else if (rstFIR) begin
            for (int k = 0; k < 8; k++) begin
                x[k] <= '0;
            end
        end
    end

    // Partial convolutions y[n] = sum Hk*x[n-k], full precision.
    always_comb begin
        logic [PW-1:0] prod;
        logic [OW-1:0] acc;
        prod = '0;
        acc  = '0;
        for (int n = 0; n < 8; n++) begin
            acc = '0;
            for (int k = 0; k <= n; k++) begin
                prod = PW'(H[k]) * PW'(x[3'(n - k)]);
                acc  = acc + OW'(prod);
            end
            y[n] = acc;
        end
    end

    // Registered output select and debug read-back of pre-edge samples.
    always_ff @(posedge clk or posedge rstFIR) begin
        if (rstFIR) begin
            bus.out_data <= '0;
            bus.mem_data <= '0;
        end else begin
            bus.out_data <= y[bus.addr];
            bus.mem_data <= x[bus.mem_addr];
        end
    end

`ifdef FIR8_OUT_VALID_EN
    // Flags an output computed from samples not being replaced.
    always_ff @(posedge clk or posedge rstFIR) begin
        if (rstFIR) begin
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= ~bus.write;
        end
    end
`endif
endmodule

// File: tb/tb_fir8_lowpass_core.sv
// Randomized and directed bench for fir8_lowpass_core.
// Reference model: plain integer convolution over a sample array.
module tb_fir8_lowpass_core;
    logic       clk;
    logic       rst_fir;
    logic [7:0] cv [8];

    int errors;
    int checks;
    int xm [8];
    int exp_out;

    int hc [8] = '{4, 12, 30, 46, 46, 30, 12, 4};
    int imp [8] = '{4, 12, 30, 46, 46, 30, 12, 4};
    int stp [8] = '{4, 16, 46, 92, 138, 168, 180, 184};

    fir8_lowpass_core_if #(.DW(8), .OW(18)) bus ();

    assign bus.c0 = cv[0];
    assign bus.c1 = cv[1];
    assign bus.c2 = cv[2];
    assign bus.c3 = cv[3];
    assign bus.c4 = cv[4];
    assign bus.c5 = cv[5];
    assign bus.c6 = cv[6];
    assign bus.c7 = cv[7];

    fir8_lowpass_core dut (
        .clk    (clk),
        .rstFIR (rst_fir),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, obs, exp);
        end
    endtask

    function automatic int ref_y(input int n);
        int s;
        s = 0;
        for (int k = 0; k <= n; k++) begin
            s += hc[k] * xm[n - k];
        end
        return s;
    endfunction

    // One clock: predict from pre-edge model, update model, compare.
    task automatic cycle();
        int eo;
        int em;
        int ev;
        eo = rst_fir ? 0 : ref_y(int'(bus.addr));
        em = rst_fir ? 0 : xm[bus.mem_addr];
        ev = (!rst_fir && !bus.write) ? 1 : 0;
        if (bus.write) begin
            for (int k = 0; k < 8; k++) xm[k] = int'(cv[k]);
        end else if (rst_fir) begin
            for (int k = 0; k < 8; k++) xm[k] = 0;
        end
        @(posedge clk);
        #1;
        exp_out = eo;
        check("out_data", 32'(bus.out_data), eo);
        check("mem_data", 32'(bus.mem_data), em);
`ifdef FIR8_OUT_VALID_EN
        check("out_valid", 32'(bus.out_valid), ev);
`else
        ev = ev;
`endif
    endtask

    task automatic load(input int r, input int n);
        rst_fir   = 1'(r);
        bus.write = 1'b1;
        repeat (n) cycle();
        rst_fir   = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic sweep_lit(input string tag, input int lit [8]);
        for (int i = 0; i < 8; i++) begin
            bus.addr = 3'(i);
            cycle();
            check(tag, 32'(bus.out_data), lit[i]);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        exp_out      = 0;
        rst_fir      = 1'b1;
        bus.write    = 1'b0;
        bus.addr     = 3'd0;
        bus.mem_addr = 3'd0;
        for (int k = 0; k < 8; k++) begin
            cv[k] = 8'd0;
            xm[k] = 0;
        end
        #1;
        check("reset_out", 32'(bus.out_data), 0);
        check("reset_mem", 32'(bus.mem_data), 0);

        // 1: clear, then both sweeps read zero
        cycle();
        rst_fir = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_addr = 3'(i);
            bus.addr     = 3'(i);
            cycle();
        end

        // 2: inputs ignored without write, then loaded
        for (int k = 0; k < 8; k++) cv[k] = 8'(k + 1);
        for (int i = 0; i < 8; i++) begin
            bus.mem_addr = 3'(i);
            cycle();
        end
        bus.write = 1'b1;
        cycle();
        bus.write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_addr = 3'(i);
            cycle();
            check("mem_lit", 32'(bus.mem_data), i + 1);
        end

        // outputs must not follow addr/c/write between edges
        bus.addr  = 3'd5;
        bus.write = 1'b1;
        cv[0]     = 8'd99;
        #2;
        check("no_comb", 32'(bus.out_data), exp_out);
        bus.write = 1'b0;
        cv[0]     = 8'd1;

        // 3: reset together with a zero load
        for (int k = 0; k < 8; k++) cv[k] = 8'd0;
        load(1, 1);
        for (int i = 0; i < 8; i++) begin
            bus.addr = 3'(i);
            cycle();
            check("zero_out", 32'(bus.out_data), 0);
        end

        // 4: impulse reproduces the coefficients
        cv[0] = 8'd1;
        load(1, 1);
        sweep_lit("impulse", imp);

        // 5: step gives running coefficient sums
        for (int k = 0; k < 8; k++) cv[k] = 8'd1;
        load(1, 1);
        sweep_lit("step", stp);

        // 6: arbitrary block
        cv = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd1};
        load(1, 1);
        for (int i = 0; i < 4; i++) begin
            bus.addr = 3'(i);
            cycle();
        end

        // delayed impulse at x[3]
        for (int k = 0; k < 8; k++) cv[k] = 8'd0;
        cv[3] = 8'd1;
        load(1, 2);
        for (int i = 0; i < 6; i++) begin
            bus.addr = 3'(i);
            cycle();
        end

        // reset mid-sweep clears outputs without an edge
        bus.addr = 3'd6;
        rst_fir  = 1'b1;
        #1;
        check("async_out", 32'(bus.out_data), 0);
        check("async_mem", 32'(bus.mem_data), 0);
        cycle();
        rst_fir = 1'b0;

        // random traffic
        for (int t = 0; t < 300; t++) begin
            rst_fir      = ($urandom_range(0, 9) == 0);
            bus.write    = ($urandom_range(0, 3) == 0);
            bus.addr     = 3'($urandom_range(0, 7));
            bus.mem_addr = 3'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++) begin
                cv[k] = 8'($urandom_range(0, 255));
            end
            cycle();
        end

        // full-scale block exercises the widest sum
        for (int k = 0; k < 8; k++) cv[k] = 8'd255;
        load(0, 1);
        bus.addr = 3'd7;
        cycle();
        check("full_scale", 32'(bus.out_data), 255 * 184);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule
